// File: rtl/pll_phase_sequencer.sv
// PLL dynamic reconfiguration sequencer: applies a requested input clock source and
// six per-counter phase targets by driving clkswitch and the phase-step handshake.
module pll_phase_sequencer #(
    parameter int SCANDIV      = 2,
    parameter int CLKSW_CYCLES = 4,
    parameter int TIMEOUT      = 1023
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        updatepll,
    input  logic        pll_clk_src,
    input  logic [47:0] pll_shifts,
    input  logic        phasedone,
    output logic [2:0]  phasecounterselect,
    output logic        phaseupdown,
    output logic        phasestep,
    output logic        scanclk,
    output logic        clkswitch,
    output logic        cur_src,
    output logic        busy,
    output logic        error
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [7:0]    DIV_MAX = 8'(SCANDIV - 1);
    localparam logic [7:0]    CSW_MAX = 8'(CLKSW_CYCLES - 1);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT);

    typedef enum logic [2:0] {IDLE, CLKSW, SCAN, SETUP, STEP, WAITLO, WAITHI} state_t;

    state_t        state_q;
    logic [7:0]    div_q;
    logic          scanclk_q;
    logic          pd_meta_q, pd_sync_q;
    logic          pending_q;
    logic          target_src_q;
    logic [47:0]   target_q;
    logic [7:0]    applied_q [6];
    logic [2:0]    idx_q;
    logic          updn_q;
    logic [7:0]    cnt_q;
    logic [1:0]    rises_q;
    logic [TW-1:0] tmo_q;
    logic [2:0]    sel_q;
    logic          phasestep_q, clkswitch_q, cur_src_q, busy_q, error_q;

    logic [7:0] delta [6];
    logic       found;
    logic [2:0] sel_d;
    logic [7:0] delta_d;

    wire scan_tick = (div_q == DIV_MAX);
    wire scan_rise = scan_tick & ~scanclk_q;
    wire scan_fall = scan_tick & scanclk_q;

    for (genvar gi = 0; gi < 6; gi++) begin : g_delta
        assign delta[gi] = target_q[gi*8 +: 8] - applied_q[gi];
    end

    // Lowest-numbered counter that still differs from its target wins.
    always_comb begin
        found   = 1'b0;
        sel_d   = 3'd0;
        delta_d = 8'd0;
        for (int k = 5; k >= 0; k--) begin
            if (delta[k] != 8'd0) begin
                found   = 1'b1;
                sel_d   = k[2:0];
                delta_d = delta[k];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q     <= 8'd0;
            scanclk_q <= 1'b0;
            pd_meta_q <= 1'b0;
            pd_sync_q <= 1'b0;
        end else begin
            pd_meta_q <= phasedone;
            pd_sync_q <= pd_meta_q;
            if (scan_tick) begin
                div_q     <= 8'd0;
                scanclk_q <= ~scanclk_q;
            end else begin
                div_q <= div_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            pending_q    <= 1'b0;
            target_src_q <= 1'b0;
            target_q     <= 48'd0;
            for (int k = 0; k < 6; k++) applied_q[k] <= 8'd0;
            idx_q        <= 3'd0;
            updn_q       <= 1'b0;
            cnt_q        <= 8'd0;
            rises_q      <= 2'd0;
            tmo_q        <= '0;
            sel_q        <= 3'd0;
            phasestep_q  <= 1'b0;
            clkswitch_q  <= 1'b0;
            cur_src_q    <= 1'b0;
            busy_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            if (updatepll && state_q != IDLE) pending_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (updatepll || pending_q) begin
                        target_src_q <= pll_clk_src;
                        target_q     <= pll_shifts;
                        pending_q    <= 1'b0;
                        busy_q       <= 1'b1;
                        cnt_q        <= 8'd0;
                        if (pll_clk_src != cur_src_q) begin
                            clkswitch_q <= 1'b1;
                            state_q     <= CLKSW;
                        end else begin
                            state_q <= SCAN;
                        end
                    end
                end
                CLKSW: begin
                    if (cnt_q == CSW_MAX) begin
                        clkswitch_q <= 1'b0;
                        cur_src_q   <= target_src_q;
                        state_q     <= SCAN;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                SCAN: begin
                    if (found) begin
                        idx_q   <= sel_d;
                        sel_q   <= sel_d;
                        updn_q  <= ~delta_d[7];
                        state_q <= SETUP;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                SETUP: begin
                    if (scan_fall) begin
                        phasestep_q <= 1'b1;
                        rises_q     <= 2'd0;
                        state_q     <= STEP;
                    end
                end
                STEP: begin
                    if (rises_q == 2'd2) begin
                        phasestep_q <= 1'b0;
                        tmo_q       <= '0;
                        state_q     <= WAITLO;
                    end else if (scan_rise) begin
                        rises_q <= rises_q + 2'd1;
                    end
                end
                WAITLO, WAITHI: begin
                    if ((state_q == WAITLO) && !pd_sync_q) begin
                        tmo_q   <= '0;
                        state_q <= WAITHI;
                    end else if ((state_q == WAITHI) && pd_sync_q) begin
                        applied_q[idx_q] <= updn_q ? applied_q[idx_q] + 8'd1
                                                   : applied_q[idx_q] - 8'd1;
                        state_q <= SCAN;
                    end else if (tmo_q == TMO_MAX) begin
                        error_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign phasecounterselect = sel_q;
    assign phaseupdown        = updn_q;
    assign phasestep          = phasestep_q;
    assign scanclk            = scanclk_q;
    assign clkswitch          = clkswitch_q;
    assign cur_src            = cur_src_q;
    assign busy               = busy_q;
    assign error              = error_q;

endmodule

// File: tb/tb_pll_phase_sequencer.sv
// Scoreboard bench: stimulus queues expected step / clkswitch / done events,
// a monitor pops and compares them as the sequencer produces them.
module tb_pll_phase_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        updatepll;
    logic        pll_clk_src;
    logic [47:0] pll_shifts;
    logic        phasedone;
    logic [2:0]  phasecounterselect;
    logic        phaseupdown, phasestep, scanclk, clkswitch, cur_src, busy, error;

    pll_phase_sequencer dut (
        .clk(clk), .reset(reset), .updatepll(updatepll), .pll_clk_src(pll_clk_src),
        .pll_shifts(pll_shifts), .phasedone(phasedone),
        .phasecounterselect(phasecounterselect), .phaseupdown(phaseupdown),
        .phasestep(phasestep), .scanclk(scanclk), .clkswitch(clkswitch),
        .cur_src(cur_src), .busy(busy), .error(error)
    );

    always #5 clk = ~clk;

    typedef struct { int kind; int a; int b; } ev_t;   // kind 0=step(sel,up) 1=clksw(width) 2=done(src,err)
    ev_t exp_q[$];
    int  n_pass = 0;
    int  n_checks = 0;
    bit  stuck = 1'b0;

    task automatic chk(input string name, input int got, input int want);
        n_checks++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, got, want);
    endtask

    task automatic push(input int kind, input int a, input int b, input int n);
        ev_t e;
        e.kind = kind; e.a = a; e.b = b;
        for (int i = 0; i < n; i++) exp_q.push_back(e);
    endtask

    task automatic got_ev(input int kind, input int a, input int b);
        ev_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            $display("FAIL unexpected_event: got kind=%0d a=%0d b=%0d expected none", kind, a, b);
            return;
        end
        e = exp_q.pop_front();
        if (e.kind == kind && e.a == a && e.b == b) begin
            n_pass++;
            $display("event kind=%0d a=%0d b=%0d ok", kind, a, b);
        end else begin
            $display("FAIL event: got kind=%0d a=%0d b=%0d expected kind=%0d a=%0d b=%0d",
                     kind, a, b, e.kind, e.a, e.b);
        end
    endtask

    // Monitor
    logic ps_prev = 1'b0, cs_prev = 1'b0, busy_prev = 1'b0;
    int   cs_width = 0;
    always @(negedge clk) begin
        if (phasestep && !ps_prev) got_ev(0, int'(phasecounterselect), int'(phaseupdown));
        if (clkswitch) cs_width++;
        if (!clkswitch && cs_prev) begin
            got_ev(1, cs_width, 0);
            cs_width = 0;
        end
        if (!busy && busy_prev) got_ev(2, int'(cur_src), int'(error));
        ps_prev   = phasestep;
        cs_prev   = clkswitch;
        busy_prev = busy;
    end

    // PLL phase-step responder
    initial begin
        forever begin
            @(posedge phasestep);
            if (!stuck) begin
                @(negedge clk);
                phasedone = 1'b0;
                if (phasestep) @(negedge phasestep);
                repeat (4) @(negedge clk);
                phasedone = 1'b1;
            end
        end
    end

    function automatic logic [47:0] sh(input logic [7:0] e0, e1, e2, e3, e4, e5);
        return {e5, e4, e3, e2, e1, e0};
    endfunction

    task automatic start(input logic src, input logic [47:0] s);
        @(negedge clk);
        pll_clk_src = src;
        pll_shifts  = s;
        updatepll   = 1'b1;
        @(negedge clk);
        updatepll   = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            n_checks++;
            $display("FAIL wait_idle: busy still high after %0d cycles expected idle", n);
        end
    endtask

    task automatic wait_step();
        int n = 0;
        while (!phasestep && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) begin
            n_checks++;
            $display("FAIL wait_step: phasestep still low after %0d cycles expected high", n);
        end
    endtask

    task automatic req(input logic src, input logic [47:0] s);
        start(src, s);
        wait_idle();
        repeat (3) @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; updatepll = 1'b0; pll_clk_src = 1'b0; pll_shifts = '0; phasedone = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_phasestep", int'(phasestep), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_error", int'(error), 0);
        chk("rst_misc", int'({clkswitch, cur_src, scanclk, phaseupdown, phasecounterselect}), 0);

        // Nothing to do
        push(2, 0, 0, 1);
        req(1'b0, '0);
        // Counter C0 (entry 2) up by 3, then down to 1
        push(0, 2, 1, 3); push(2, 0, 0, 1);
        req(1'b0, sh(0, 0, 3, 0, 0, 0));
        push(0, 2, 0, 2); push(2, 0, 0, 1);
        req(1'b0, sh(0, 0, 1, 0, 0, 0));
        // Source change, then repeat with no change
        push(1, 4, 0, 1); push(2, 1, 0, 1);
        req(1'b1, sh(0, 0, 1, 0, 0, 0));
        chk("cur_src_after_switch", int'(cur_src), 1);
        push(2, 1, 0, 1);
        req(1'b1, sh(0, 0, 1, 0, 0, 0));
        // Wrap-around: 0xFE steps down twice, entry 5 up once afterwards
        push(0, 0, 0, 2); push(0, 5, 1, 1); push(2, 1, 0, 1);
        req(1'b1, sh(8'hFE, 0, 1, 0, 0, 1));
        // Timeout with phasedone stuck high, then retry with a live PLL
        stuck = 1'b1;
        push(0, 1, 1, 1); push(2, 1, 1, 1);
        req(1'b1, sh(8'hFE, 1, 1, 0, 0, 1));
        chk("timeout_phasestep", int'(phasestep), 0);
        stuck = 1'b0;
        push(0, 1, 1, 1); push(2, 1, 1, 1);
        req(1'b1, sh(8'hFE, 1, 1, 0, 0, 1));
        // Re-trigger while stepping: pending request re-samples new targets
        push(0, 3, 1, 2); push(2, 1, 1, 1); push(0, 3, 1, 1); push(2, 1, 1, 1);
        start(1'b1, sh(8'hFE, 1, 1, 2, 0, 1));
        wait_step();
        pll_shifts = sh(8'hFE, 1, 1, 3, 0, 1);
        updatepll  = 1'b1;
        @(negedge clk);
        updatepll  = 1'b0;
        wait_idle();
        repeat (2) @(negedge clk);
        wait_idle();
        repeat (3) @(negedge clk);
        // Asynchronous reset in the middle of a step
        push(0, 3, 1, 1); push(2, 0, 0, 1);
        start(1'b1, sh(8'hFE, 1, 1, 5, 0, 1));
        wait_step();
        #2 reset = 1'b1;
        @(negedge clk);
        chk("midrst_phasestep", int'(phasestep), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_error", int'(error), 0);
        chk("midrst_misc", int'({clkswitch, cur_src, scanclk, phaseupdown, phasecounterselect}), 0);
        repeat (8) @(negedge clk);
        reset = 1'b0;
        // Applied registers were cleared: an all-zero request needs no steps
        push(2, 0, 0, 1);
        req(1'b0, '0);

        chk("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
